// File: rtl/odd_parity_serial_checker_pkg.sv
// Shared definitions for the odd-parity link: receiver FSM state encoding and the
// parity function used identically by the generator and the checker.
package odd_parity_serial_checker_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

    // Widest data vector the parity helper accepts; callers zero-extend into it,
    // which leaves the parity of the vector unchanged.
    localparam int ODD_PAR_MAX_W = 64;

    // Parity bit that makes vec plus the bit contain an odd number of ones.
    function automatic logic odd_par(input logic [ODD_PAR_MAX_W-1:0] vec);
        return ~^vec;
    endfunction

endpackage

// File: rtl/odd_parity_checker_core.sv
// Combinational odd-parity check: ok=1 when data plus parity hold an odd number of ones.
// Zero latency, no flow control; recomputes the generator's parity bit and compares.
module odd_parity_checker_core
    import odd_parity_serial_checker_pkg::*;
#(
    parameter int DATA_W = 3
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par,
    output logic              ok
);

    logic [ODD_PAR_MAX_W-1:0] data_ext;

    assign data_ext = ODD_PAR_MAX_W'(data);
    assign ok       = (par == odd_par(data_ext));

endmodule

// File: rtl/odd_parity_serial_checker.sv
// Odd-parity serial receiver: start, DATA_W data bits LSB first, parity, stop; one bit per bit_en.
// data_valid pulses 1 clk after the stop-bit sample; no backpressure, the consumer must take each pulse.
module odd_parity_serial_checker
    import odd_parity_serial_checker_pkg::*;
#(
    parameter int DATA_W   = 3,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_en,
    input  logic                serial_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_q;
    logic              par_ok;

    odd_parity_checker_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .data (shreg),
        .par  (par_q),
        .ok   (par_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            err_count  <= '0;
        end else begin
            // The valid pulse is one clk wide regardless of the bit-rate strobe.
            data_valid <= 1'b0;
            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            shreg   <= '0;
                        end
                    end
                    DATA: begin
                        shreg[bit_cnt] <= serial_in;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        par_q <= serial_in;
                        state <= STOP;
                    end
                    STOP: begin
                        data_out   <= shreg;
                        parity_err <= ~par_ok;
                        frame_err  <= ~serial_in;
                        data_valid <= 1'b1;
                        // A bad stop bit does not exempt the frame from parity counting.
                        if (!par_ok && (err_count != '1)) begin
                            err_count <= err_count + 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_odd_parity_serial_checker.sv
// Directed bench for odd_parity_serial_checker: two instances (8-bit and 2-bit error counter)
// share one serial line and are checked every cycle against a frame-level model.
module tb_odd_parity_serial_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       serial_in;

    logic [2:0] data_a, data_b;
    logic       dv_a, dv_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    odd_parity_serial_checker #(.DATA_W(3), .ERRCNT_W(8)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_out   (data_a),
        .data_valid (dv_a),
        .parity_err (pe_a),
        .frame_err  (fe_a),
        .busy       (busy_a),
        .err_count  (cnt_a)
    );

    odd_parity_serial_checker #(.DATA_W(3), .ERRCNT_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_out   (data_b),
        .data_valid (dv_b),
        .parity_err (pe_b),
        .frame_err  (fe_b),
        .busy       (busy_b),
        .err_count  (cnt_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulse_cycle = -1;
    int n_pulses = 0;
    logic chk_en = 1'b0;

    // Frame-level model state
    logic [2:0] m_data = 3'b000;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_busy = 1'b0;
    int         m_errs = 0;

    int exp_sat2 [5] = '{1, 2, 3, 3, 3};
    logic [2:0] bad_words [5] = '{3'b010, 3'b111, 3'b000, 3'b100, 3'b011};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (dv_a === 1'b1) n_pulses++;
        if (chk_en) begin
            check("data_valid",   {31'd0, dv_a},   {31'd0, cyc == pulse_cycle});
            check("data_valid_b", {31'd0, dv_b},   {31'd0, cyc == pulse_cycle});
            check("data_out",     {29'd0, data_a}, {29'd0, m_data});
            check("data_out_b",   {29'd0, data_b}, {29'd0, m_data});
            check("parity_err",   {31'd0, pe_a},   {31'd0, m_perr});
            check("parity_err_b", {31'd0, pe_b},   {31'd0, m_perr});
            check("frame_err",    {31'd0, fe_a},   {31'd0, m_ferr});
            check("frame_err_b",  {31'd0, fe_b},   {31'd0, m_ferr});
            check("busy",         {31'd0, busy_a}, {31'd0, m_busy});
            check("busy_b",       {31'd0, busy_b}, {31'd0, m_busy});
            check("err_count8",   {24'd0, cnt_a},  sat(m_errs, 255));
            check("err_count2",   {30'd0, cnt_b},  sat(m_errs, 3));
        end
    end

    // Present one line bit; bit_en pulses on the last clk of each period.
    task automatic put_bit(input logic b, input int period);
        serial_in = b;
        bit_en    = 1'b0;
        repeat (period - 1) begin
            @(posedge clk);
            #1;
        end
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p, input logic stop, input int period);
        put_bit(1'b0, period);
        m_busy = 1'b1;
        for (int i = 0; i < 3; i++) put_bit(d[i], period);
        put_bit(p, period);
        put_bit(stop, period);
        m_busy      = 1'b0;
        m_data      = d;
        m_perr      = ($countones({d, p}) % 2) == 0;
        m_ferr      = !stop;
        if (m_perr) m_errs++;
        pulse_cycle = cyc;
    endtask

    task automatic idle_bits(input int n, input int period);
        for (int i = 0; i < n; i++) put_bit(1'b1, period);
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        serial_in = 1'b1;
        bit_en    = 1'b0;
        rst       = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst         = 1'b0;
        m_data      = 3'b000;
        m_perr      = 1'b0;
        m_ferr      = 1'b0;
        m_busy      = 1'b0;
        m_errs      = 0;
        pulse_cycle = -1;
        check("rst_busy",       {31'd0, busy_a}, 32'd0);
        check("rst_data_valid", {31'd0, dv_a},   32'd0);
        check("rst_err_count",  {24'd0, cnt_a},  32'd0);
        check("rst_data_out",   {29'd0, data_a}, 32'd0);
        chk_en = 1'b1;
    endtask

    int p0;

    initial begin
        rst       = 1'b1;
        bit_en    = 1'b0;
        serial_in = 1'b1;
        do_reset();
        idle_bits(2, 1);

        // Test 1: reset after start + 2 data bits, then a clean frame
        put_bit(1'b0, 1);
        m_busy = 1'b1;
        put_bit(1'b1, 1);
        put_bit(1'b0, 1);
        check("t1_busy_midframe", {31'd0, busy_a}, 32'd1);
        do_reset();
        send_frame(3'b110, 1'b1, 1'b1, 1);
        check("t1_data", {29'd0, data_a}, 32'd6);
        check("t1_perr", {31'd0, pe_a}, 32'd0);
        idle_bits(1, 1);

        // Test 2: all eight words, correct parity, back to back
        p0 = n_pulses;
        for (int w = 0; w < 8; w++) begin
            logic [2:0] wv;
            wv = 3'(w);
            send_frame(wv, ~^wv, 1'b1, 1);
            check("t2_data", {29'd0, data_a}, w);
        end
        idle_bits(2, 1);
        check("t2_pulses", n_pulses - p0, 32'd8);
        check("t2_errcnt", {24'd0, cnt_a}, 32'd0);

        // Test 3: 101 carries two ones, so p=0 is the wrong parity
        send_frame(3'b101, 1'b0, 1'b1, 1);
        check("t3_data", {29'd0, data_a}, 32'd5);
        check("t3_perr", {31'd0, pe_a}, 32'd1);
        check("t3_ferr", {31'd0, fe_a}, 32'd0);
        check("t3_errcnt", {24'd0, cnt_a}, 32'd1);
        idle_bits(1, 1);

        // Test 4: good parity, stop bit 0
        send_frame(3'b011, 1'b1, 1'b0, 1);
        check("t4_ferr", {31'd0, fe_a}, 32'd1);
        check("t4_perr", {31'd0, pe_a}, 32'd0);
        idle_bits(1, 1);

        // Break: all zeros gives data 0 with frame and parity error
        send_frame(3'b000, 1'b0, 1'b0, 1);
        check("brk_data", {29'd0, data_a}, 32'd0);
        check("brk_ferr", {31'd0, fe_a}, 32'd1);
        check("brk_errcnt", {24'd0, cnt_a}, 32'd2);
        idle_bits(2, 1);

        // Test 5: bit_en every 4th clk, back-to-back frames
        p0 = n_pulses;
        send_frame(3'b110, 1'b1, 1'b1, 4);
        check("t5_data0", {29'd0, data_a}, 32'd6);
        send_frame(3'b001, 1'b0, 1'b1, 4);
        check("t5_data1", {29'd0, data_a}, 32'd1);
        idle_bits(2, 4);
        check("t5_pulses", n_pulses - p0, 32'd2);

        // Test 6: saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame(bad_words[i], ^bad_words[i], 1'b1, 1);
            check("t6_errcnt2", {30'd0, cnt_b}, exp_sat2[i]);
            check("t6_errcnt8", {24'd0, cnt_a}, i + 1);
            idle_bits(1, 1);
        end
        idle_bits(2, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
